clock_period_meter: RTL and testbench

- Sits directly downstream of the clock divider.
- Samples the divider output (`clk_mon`) in the `clk_ref` domain and measures its period and high time in `clk_ref` cycles.
- Reports each measurement and flags lock once the period is stable.
- Used on-chip and in benches to confirm that a programmed divide factor actually took effect.

---
 rtl/clk_meter_pkg.sv | 14 +
 rtl/sync_edge_det.sv | 30 +++
 rtl/clock_period_meter.sv | 170 +++++++++++++++++
 tb/tb_clock_period_meter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_meter_pkg.sv
// Shared definitions for the clock period meter: FSM encoding, default width
// and the counter saturation value.
package clk_meter_pkg;

  localparam int unsigned CNT_W_DEF = 32;
  localparam logic [CNT_W_DEF-1:0] CNT_SAT_DEF = {CNT_W_DEF{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizes the monitored clock into the reference domain and flags its
// rising edges; rise is aligned with the cycle in which mon_s first reads 1.
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_ref,
  input  logic rst,
  input  logic din,
  output logic mon_s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   mon_d;

  // Flop chain plus one delay stage for edge detection
  always_ff @(posedge clk_ref or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      mon_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      mon_d  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign mon_s = sync_q[SYNC_STAGES-1];
  assign rise  = mon_s & ~mon_d;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of clk_mon in clk_ref cycles and flags lock.
// Optional expected-period checker: define CLK_PERIOD_METER_EXPECT_EN.
module clock_period_meter
  import clk_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_COUNT  = 4
) (
  input  logic             clk_ref,
  input  logic             rst,
  input  logic             enable,
  input  logic             clk_mon,
`ifdef CLK_PERIOD_METER_EXPECT_EN
  input  logic [CNT_W-1:0] expected_period,
  output logic             period_err,
`endif
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             overflow
);

  localparam int unsigned        MATCH_W   = $clog2(LOCK_COUNT);
  localparam logic [MATCH_W-1:0] MATCH_MAX = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [CNT_W-1:0]   CNT_SAT   = {CNT_W{1'b1}};

  logic mon_s;
  logic rise;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   hcnt_q, hcnt_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic               have_prev_q, have_prev_d;
  logic [CNT_W-1:0]   period_d, high_d;
  logic               valid_d, locked_d, ovf_d;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_ref (clk_ref),
    .rst     (rst),
    .din     (clk_mon),
    .mon_s   (mon_s),
    .rise    (rise)
  );

  // State, counters and registered outputs
  always_ff @(posedge clk_ref or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hcnt_q      <= '0;
      match_q     <= '0;
      have_prev_q <= 1'b0;
      period      <= '0;
      high_time   <= '0;
      meas_valid  <= 1'b0;
      locked      <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hcnt_q      <= hcnt_d;
      match_q     <= match_d;
      have_prev_q <= have_prev_d;
      period      <= period_d;
      high_time   <= high_d;
      meas_valid  <= valid_d;
      locked      <= locked_d;
      overflow    <= ovf_d;
    end
  end

  // Next-state, counting, capture and lock tracking
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hcnt_d      = hcnt_q;
    match_d     = match_q;
    have_prev_d = have_prev_q;
    period_d    = period;
    high_d      = high_time;
    valid_d     = 1'b0;
    locked_d    = locked;
    ovf_d       = overflow;

    if (!enable) begin
      state_d     = IDLE;
      cnt_d       = '0;
      hcnt_d      = '0;
      match_d     = '0;
      have_prev_d = 1'b0;
      locked_d    = 1'b0;
      ovf_d       = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d     = ARM;
          have_prev_d = 1'b0;
        end
        ARM: begin
          if (rise) begin
            cnt_d   = CNT_W'(1);
            hcnt_d  = CNT_W'(1);
            state_d = MEAS;
          end
        end
        MEAS: begin
          if (rise) begin
            period_d    = cnt_q;
            high_d      = hcnt_q;
            valid_d     = 1'b1;
            cnt_d       = CNT_W'(1);
            hcnt_d      = CNT_W'(1);
            have_prev_d = 1'b1;
            // First capture after arming has nothing to compare against
            if (have_prev_q && (cnt_q == period)) begin
              if (match_q != MATCH_MAX) match_d = match_q + MATCH_W'(1);
            end else begin
              match_d = '0;
            end
            locked_d = (match_d == MATCH_MAX);
          end else if (cnt_q == CNT_SAT) begin
            ovf_d       = 1'b1;
            locked_d    = 1'b0;
            match_d     = '0;
            have_prev_d = 1'b0;
            state_d     = ARM;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (mon_s) hcnt_d = hcnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef CLK_PERIOD_METER_EXPECT_EN
  logic lock_seen_q, lock_seen_d;
  logic err_d;

  // Once lock has been seen, any captured period off target sets a sticky error
  always_comb begin
    lock_seen_d = lock_seen_q;
    err_d       = period_err;
    if (!enable) begin
      lock_seen_d = 1'b0;
      err_d       = 1'b0;
    end else if (valid_d) begin
      if (lock_seen_q && (cnt_q != expected_period)) err_d = 1'b1;
      if (locked_d) lock_seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk_ref or negedge rst) begin
    if (!rst) begin
      lock_seen_q <= 1'b0;
      period_err  <= 1'b0;
    end else begin
      lock_seen_q <= lock_seen_d;
      period_err  <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter (CNT_W=8): table-driven period
// sequences plus enable-drop, async reset and overflow sequences.
module tb_clock_period_meter;

  localparam int unsigned CNT_W = 8;

  logic             clk_ref = 1'b0;
  logic             rst     = 1'b0;
  logic             enable  = 1'b0;
  logic             clk_mon = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             locked;
  logic             overflow;
`ifdef CLK_PERIOD_METER_EXPECT_EN
  logic [CNT_W-1:0] expected_period = 8'd4;
  logic             period_err;
`endif

  clock_period_meter #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (2),
    .LOCK_COUNT  (4)
  ) dut (
    .clk_ref         (clk_ref),
    .rst             (rst),
    .enable          (enable),
    .clk_mon         (clk_mon),
`ifdef CLK_PERIOD_METER_EXPECT_EN
    .expected_period (expected_period),
    .period_err      (period_err),
`endif
    .period          (period),
    .high_time       (high_time),
    .meas_valid      (meas_valid),
    .locked          (locked),
    .overflow        (overflow)
  );

  always #5 clk_ref = ~clk_ref;

  // clk_mon generator: new period/high take effect at the next rising edge
  int gen_per = 4;
  int gen_hi  = 2;
  int nxt_per = 4;
  int nxt_hi  = 2;
  int ph      = 3;

  initial begin
    forever begin
      @(negedge clk_ref);
      if (ph >= gen_per - 1) begin
        ph      = 0;
        gen_per = nxt_per;
        gen_hi  = nxt_hi;
      end else begin
        ph = ph + 1;
      end
      clk_mon = (ph < gen_hi);
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Wait for the next meas_valid pulse, sampling 1 ns after each rising edge
  task automatic wait_valid(input string name, output int cyc);
    bit ok;
    ok  = 1'b0;
    cyc = 0;
    while (!ok && cyc < 400) begin
      @(posedge clk_ref);
      #1;
      cyc = cyc + 1;
      if (meas_valid) ok = 1'b1;
    end
    check({name, "_timeout"}, 32'(ok), 1);
  endtask

  typedef struct {
    int per;
    int hi;
    int ep;
    int eh;
    bit el;
    bit eerr;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int cyc;
    int n;
    int pulses;

    // per/hi: generator setting; ep/eh/el: expected capture; eerr: period_err
    tbl[0]  = '{4,   2, 4,   2, 1'b0, 1'b0};
    tbl[1]  = '{4,   2, 4,   2, 1'b0, 1'b0};
    tbl[2]  = '{4,   2, 4,   2, 1'b0, 1'b0};
    tbl[3]  = '{4,   2, 4,   2, 1'b1, 1'b0};
    tbl[4]  = '{5,   2, 4,   2, 1'b1, 1'b0};
    tbl[5]  = '{5,   2, 5,   2, 1'b0, 1'b1};
    tbl[6]  = '{5,   2, 5,   2, 1'b0, 1'b1};
    tbl[7]  = '{5,   2, 5,   2, 1'b0, 1'b1};
    tbl[8]  = '{5,   2, 5,   2, 1'b1, 1'b1};
    tbl[9]  = '{6,   4, 5,   2, 1'b1, 1'b1};
    tbl[10] = '{6,   4, 6,   4, 1'b0, 1'b1};
    tbl[11] = '{255, 1, 6,   4, 1'b0, 1'b1};
    tbl[12] = '{255, 1, 255, 1, 1'b0, 1'b1};
    tbl[13] = '{4,   2, 255, 1, 1'b0, 1'b1};
    tbl[14] = '{4,   2, 4,   2, 1'b0, 1'b1};
    tbl[15] = '{4,   2, 4,   2, 1'b0, 1'b1};
    tbl[16] = '{4,   2, 4,   2, 1'b0, 1'b1};
    tbl[17] = '{4,   2, 4,   2, 1'b1, 1'b1};

    // Reset values
    repeat (3) @(posedge clk_ref);
    #1;
    check("rst_period", 32'(period), 0);
    check("rst_high", 32'(high_time), 0);
    check("rst_valid", 32'(meas_valid), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_overflow", 32'(overflow), 0);
`ifdef CLK_PERIOD_METER_EXPECT_EN
    check("rst_period_err", 32'(period_err), 0);
`endif

    @(negedge clk_ref);
    rst = 1'b1;
    @(negedge clk_ref);
    enable = 1'b1;

    // Table: each row is the next captured measurement
    for (int i = 0; i < 18; i++) begin
      nxt_per = tbl[i].per;
      nxt_hi  = tbl[i].hi;
      wait_valid($sformatf("tbl%0d", i), cyc);
      check($sformatf("tbl%0d_period", i), 32'(period), tbl[i].ep);
      check($sformatf("tbl%0d_high", i), 32'(high_time), tbl[i].eh);
      check($sformatf("tbl%0d_locked", i), 32'(locked), 32'(tbl[i].el));
      check($sformatf("tbl%0d_overflow", i), 32'(overflow), 0);
`ifdef CLK_PERIOD_METER_EXPECT_EN
      check($sformatf("tbl%0d_period_err", i), 32'(period_err), 32'(tbl[i].eerr));
`endif
      @(posedge clk_ref);
      #1;
      check($sformatf("tbl%0d_pulse", i), 32'(meas_valid), 0);
    end

    // Enable drop for 3 cycles while locked at period 4
    enable = 1'b0;
    @(posedge clk_ref);
    #1;
    check("en_locked", 32'(locked), 0);
    check("en_valid", 32'(meas_valid), 0);
    check("en_overflow", 32'(overflow), 0);
    check("en_period_hold", 32'(period), 4);
    check("en_high_hold", 32'(high_time), 2);
`ifdef CLK_PERIOD_METER_EXPECT_EN
    check("en_period_err", 32'(period_err), 0);
`endif
    repeat (2) @(posedge clk_ref);
    #1;
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_valid($sformatf("relock%0d", k), cyc);
      check($sformatf("relock%0d_period", k), 32'(period), 4);
      check($sformatf("relock%0d_locked", k), 32'(locked), (k == 3) ? 1 : 0);
    end

    // Asynchronous reset mid-period while locked
    @(posedge clk_ref);
    #3;
    rst = 1'b0;
    #1;
    check("arst_period", 32'(period), 0);
    check("arst_high", 32'(high_time), 0);
    check("arst_valid", 32'(meas_valid), 0);
    check("arst_locked", 32'(locked), 0);
    check("arst_overflow", 32'(overflow), 0);
    repeat (2) @(posedge clk_ref);
    n = 0;
    do begin
      @(posedge clk_ref);
      #2;
      n = n + 1;
    end while (clk_mon != 1'b0 && n < 20);
    rst = 1'b1;
    wait_valid("arst_first", cyc);
    check("arst_first_late", 32'(cyc >= 5), 1);
    check("arst_first_period", 32'(period), 4);
    check("arst_first_high", 32'(high_time), 2);
    check("arst_first_locked", 32'(locked), 0);

    // Overflow: one short pulse followed by a long low stretch
    nxt_per = 300;
    nxt_hi  = 1;
    wait_valid("ovf_stale", cyc);
    check("ovf_stale_period", 32'(period), 4);
    n      = 0;
    pulses = 0;
    while (!overflow && n < 400) begin
      @(posedge clk_ref);
      #1;
      n = n + 1;
      if (meas_valid) pulses = pulses + 1;
    end
    check("ovf_cycles", 32'(n), 255);
    check("ovf_no_valid", 32'(pulses), 0);
    check("ovf_locked", 32'(locked), 0);
    nxt_per = 4;
    nxt_hi  = 2;
    wait_valid("ovf_resume", cyc);
    check("ovf_resume_period", 32'(period), 4);
    check("ovf_resume_high", 32'(high_time), 2);
    check("ovf_sticky", 32'(overflow), 1);
    check("ovf_resume_locked", 32'(locked), 0);
    wait_valid("ovf_resume2", cyc);
    check("ovf_resume2_period", 32'(period), 4);
    check("ovf_sticky2", 32'(overflow), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
